mealy_seq_detector_param: RTL

Parametrised Mealy serial sequence detector, the next generation of the fixed 1010 detectors. Pattern width, default pattern and counter width are parameters. The pattern can be reloaded at run time, and overlap/non-overlap is a run-time mode. Adds an input-valid qualifier and a saturating match counter. Used in serial-stream monitors where several patterns and modes are needed from one block.

---
 rtl/mealy_seq_detector_param_if.sv | 36 +++
 rtl/mealy_seq_detector_param.sv | 94 +++++++++
 2 files changed

// File: rtl/mealy_seq_detector_param_if.sv
// -----------------------------------------------------------------------------
// mealy_seq_detector_param_if
// Bundles the serial-stream and control signals of mealy_seq_detector_param.
//   in_valid  : qualifies in; a cycle with in_valid=0 is ignored
//   in        : serial data bit
//   overlap   : 1 = overlapping detection, 0 = non-overlapping
//   pat_load  : load pat_in as the new pattern (bit discarded that cycle)
//   pat_in    : new pattern, MSB is the first bit received
//   cnt_clr   : synchronous clear of match_cnt
//   out       : combinational Mealy match pulse
//   match_cnt : saturating match counter
// master = stream source / monitor, slave = detector.
// -----------------------------------------------------------------------------
interface mealy_seq_detector_param_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in;
  logic             overlap;
  logic             pat_load;
  logic [N-1:0]     pat_in;
  logic             cnt_clr;
  logic             out;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output in_valid, in, overlap, pat_load, pat_in, cnt_clr,
    input  out, match_cnt
  );

  modport slave (
    input  in_valid, in, overlap, pat_load, pat_in, cnt_clr,
    output out, match_cnt
  );
endinterface

// File: rtl/mealy_seq_detector_param.sv
// -----------------------------------------------------------------------------
// mealy_seq_detector_param
// Parametrised Mealy serial sequence detector with run-time pattern reload,
// run-time overlap mode, input-valid qualifier and saturating match counter.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset (0 = reset)
//   bus : mealy_seq_detector_param_if.slave (stream, control, out, match_cnt)
// Parameters:
//   N               : pattern length, 2..16
//   DEFAULT_PATTERN : pattern after reset, bit N-1 is received first
//   CNT_W           : match counter width
// -----------------------------------------------------------------------------
module mealy_seq_detector_param #(
  parameter int           N               = 4,
  parameter logic [N-1:0] DEFAULT_PATTERN = 4'b1010,
  parameter int           CNT_W           = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  mealy_seq_detector_param_if.slave     bus
);

  localparam int               FILL_W    = $clog2(N);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N - 1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [N-1:0]      pat_q,  pat_d;
  logic [N-2:0]      hist_q, hist_d;   // newest accepted bit in bit 0
  logic [FILL_W-1:0] fill_q, fill_d;   // valid bits in hist, saturates at N-1
  logic [CNT_W-1:0]  cnt_q,  cnt_d;

  logic         accepted;
  logic         match;
  logic [N-1:0] window;

  // pat_load wins over the data bit, so a load cycle is never an accepted bit.
  assign accepted = bus.in_valid & ~bus.pat_load;
  assign window   = {hist_q, bus.in};
  assign match    = accepted & (fill_q == FILL_FULL) & (window == pat_q);

  // Registers are already cleared while rst=0, but gate explicitly so the
  // pulse is held low for the whole reset interval regardless of inputs.
  assign bus.out       = match & rst;
  assign bus.match_cnt = cnt_q;

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;

    if (bus.pat_load) begin
      pat_d  = bus.pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (accepted) begin
      if (match && !bus.overlap) begin
        // Non-overlapping: the next match must be built from N fresh bits.
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window[N-2:0];
        if (fill_q != FILL_FULL) begin
          fill_d = fill_q + FILL_ONE;
        end
      end
    end

    // Clear beats a same-cycle match; that match is dropped.
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q  <= DEFAULT_PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
